jk_ff_bank: RTL and testbench

JK_FF_BANK -- requirements
Module: jk_ff_bank

---
 rtl/jk_ff_bank_pkg.sv | 12 +
 rtl/jk_ff_bank_next.sv | 43 ++++
 rtl/jk_ff_bank.sv | 88 ++++++++
 tb/tb_jk_ff_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/jk_ff_bank_pkg.sv
// Shared mode encodings and types for the JK flip-flop bank.
// The mode value picks how each channel reads its j/k pair.
package jk_ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK = 2'b00;
    localparam mode_t MODE_T  = 2'b01;
    localparam mode_t MODE_D  = 2'b10;
    localparam mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/jk_ff_bank_next.sv
// Stateless per-channel next-state logic for one flip-flop of the bank.
// The illegal output flags S=R=1 in SR mode; that bit keeps its value.
module jk_next
    import jk_ff_bank_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       q,
    output logic       q_next,
    output logic       illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_T: begin
                q_next = j ? ~q : q;
            end
            MODE_D: begin
                q_next = j;
            end
            default: begin
                case ({j, k})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   illegal = 1'b1;
                    default: q_next = q;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with parallel load, change mask,
// saturating change-event counter and an SR illegal-input pulse.
module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q,       q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
    logic             sr_err_q,  sr_err_d;

    logic [WIDTH-1:0] bit_next;
    logic [WIDTH-1:0] bit_illegal;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            jk_next u_next (
                .mode    (mode),
                .j       (j[gi]),
                .k       (k[gi]),
                .q       (q_q[gi]),
                .q_next  (bit_next[gi]),
                .illegal (bit_illegal[gi])
            );
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (en) begin
            q_d = bit_next;
        end

        changed_d = q_d ^ q_q;
        // Only a J/K-driven SR update can be illegal; a load masks it.
        sr_err_d  = en && !load && (mode == MODE_SR) && (|bit_illegal);

        chg_cnt_d = chg_cnt_q;
        if (cnt_clr) begin
            chg_cnt_d = '0;
        end else if ((|changed_d) && (chg_cnt_q != CNT_MAX)) begin
            chg_cnt_d = chg_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            changed_q <= '0;
            chg_cnt_q <= '0;
            sr_err_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            chg_cnt_q <= chg_cnt_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign q       = q_q;
    assign qb      = ~q_q;
    assign changed = changed_q;
    assign chg_cnt = chg_cnt_q;
    assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench for jk_ff_bank: a default-size instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_jk_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] load_data;
    logic       cnt_clr;

    logic [7:0] q, qb, changed, chg_cnt;
    logic       sr_err;
    logic [7:0] q2, qb2, changed2;
    logic [1:0] chg_cnt2;
    logic       sr_err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jk_ff_bank #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_data(load_data), .cnt_clr(cnt_clr),
        .q(q), .qb(qb), .changed(changed), .chg_cnt(chg_cnt), .sr_err(sr_err)
    );

    jk_ff_bank #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_data(load_data), .cnt_clr(cnt_clr),
        .q(q2), .qb(qb2), .changed(changed2), .chg_cnt(chg_cnt2), .sr_err(sr_err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0;
        load = 1'b0; load_data = '0; cnt_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
        total++; if (qb !== 8'hFF) begin bad++; $display("FAIL reset_qb got=%h exp=FF", qb); end
        total++; if (changed !== 8'h00) begin bad++; $display("FAIL reset_changed got=%h exp=00", changed); end
        total++; if (chg_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", chg_cnt); end
        total++; if (sr_err !== 1'b0) begin bad++; $display("FAIL reset_sr_err got=%b exp=0", sr_err); end
        $display("reset: q=%h qb=%h changed=%h cnt=%0d", q, qb, changed, chg_cnt);
    endtask

    task automatic test_jk();
        en = 1'b1; mode = 2'b00; j = 8'hF0; k = 8'h0F;
        step();
        total++; if (q !== 8'hF0) begin bad++; $display("FAIL jk_setclr_q got=%h exp=F0", q); end
        total++; if (changed !== 8'hF0) begin bad++; $display("FAIL jk_setclr_changed got=%h exp=F0", changed); end
        total++; if (chg_cnt !== 8'd1) begin bad++; $display("FAIL jk_setclr_cnt got=%0d exp=1", chg_cnt); end
        $display("jk set/clr: q=%h changed=%h cnt=%0d", q, changed, chg_cnt);
        j = 8'hFF; k = 8'hFF;
        step();
        total++; if (q !== 8'h0F) begin bad++; $display("FAIL jk_toggle_q got=%h exp=0F", q); end
        total++; if (qb !== 8'hF0) begin bad++; $display("FAIL jk_toggle_qb got=%h exp=F0", qb); end
        total++; if (changed !== 8'hFF) begin bad++; $display("FAIL jk_toggle_changed got=%h exp=FF", changed); end
        total++; if (chg_cnt !== 8'd2) begin bad++; $display("FAIL jk_toggle_cnt got=%0d exp=2", chg_cnt); end
        $display("jk toggle: q=%h changed=%h cnt=%0d", q, changed, chg_cnt);
        j = 8'h00; k = 8'h00;
        step();
        total++; if (q !== 8'h0F) begin bad++; $display("FAIL jk_hold_q got=%h exp=0F", q); end
        total++; if (changed !== 8'h00) begin bad++; $display("FAIL jk_hold_changed got=%h exp=00", changed); end
        total++; if (chg_cnt !== 8'd2) begin bad++; $display("FAIL jk_hold_cnt got=%0d exp=2", chg_cnt); end
        $display("jk hold: q=%h changed=%h cnt=%0d", q, changed, chg_cnt);
    endtask

    task automatic test_toggle_mode();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h81; exp_q[1] = 8'h00; exp_q[2] = 8'h81;
        load = 1'b1; load_data = 8'h00;
        step();
        load = 1'b0;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL t_preload_q got=%h exp=00", q); end
        mode = 2'b01; j = 8'h81; k = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (q !== exp_q[i]) begin bad++; $display("FAIL t_edge%0d_q got=%h exp=%h", i, q, exp_q[i]); end
            $display("t edge %0d: q=%h changed=%h", i, q, changed);
        end
        // preload (0F->00) plus three toggling edges on top of the previous 2
        total++; if (chg_cnt !== 8'd6) begin bad++; $display("FAIL t_cnt got=%0d exp=6", chg_cnt); end
    endtask

    task automatic test_sr();
        load = 1'b1; load_data = 8'h00;
        step();
        load = 1'b0; mode = 2'b11; j = 8'h03; k = 8'h01;
        step();
        total++; if (q !== 8'h02) begin bad++; $display("FAIL sr_q got=%h exp=02", q); end
        total++; if (sr_err !== 1'b1) begin bad++; $display("FAIL sr_err_pulse got=%b exp=1", sr_err); end
        $display("sr illegal: q=%h sr_err=%b", q, sr_err);
        en = 1'b0;
        step();
        total++; if (sr_err !== 1'b0) begin bad++; $display("FAIL sr_err_clear got=%b exp=0", sr_err); end
        total++; if (q !== 8'h02) begin bad++; $display("FAIL sr_hold_q got=%h exp=02", q); end
        $display("sr after: q=%h sr_err=%b", q, sr_err);
        en = 1'b1; load = 1'b1; load_data = 8'h02;
        step();
        load = 1'b0;
        total++; if (sr_err !== 1'b0) begin bad++; $display("FAIL sr_err_load_mask got=%b exp=0", sr_err); end
        $display("sr with load: q=%h sr_err=%b", q, sr_err);
    endtask

    task automatic test_load();
        en = 1'b1; mode = 2'b10; j = 8'h00; load = 1'b1; load_data = 8'hA5;
        step();
        load = 1'b0;
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL load_q got=%h exp=A5", q); end
        total++; if (changed !== 8'hA7) begin bad++; $display("FAIL load_changed got=%h exp=A7", changed); end
        $display("load: q=%h changed=%h", q, changed);
        en = 1'b0; j = 8'h3C;
        step();
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL load_hold_q got=%h exp=A5", q); end
        total++; if (changed !== 8'h00) begin bad++; $display("FAIL load_hold_changed got=%h exp=00", changed); end
        j = 8'hC3;
        step();
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL load_hold2_q got=%h exp=A5", q); end
        $display("hold: q=%h changed=%h", q, changed);
        en = 1'b1;
        step();
        total++; if (q !== 8'hC3) begin bad++; $display("FAIL d_mode_q got=%h exp=C3", q); end
        $display("d mode: q=%h changed=%h", q, changed);
    endtask

    task automatic test_reset_override();
        rst = 1'b1; load = 1'b1; load_data = 8'h5A; en = 1'b1; cnt_clr = 1'b1; j = 8'hFF;
        step();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_ovr_q got=%h exp=00", q); end
        total++; if (qb !== 8'hFF) begin bad++; $display("FAIL rst_ovr_qb got=%h exp=FF", qb); end
        total++; if (chg_cnt !== 8'd0) begin bad++; $display("FAIL rst_ovr_cnt got=%0d exp=0", chg_cnt); end
        total++; if (changed !== 8'h00) begin bad++; $display("FAIL rst_ovr_changed got=%h exp=00", changed); end
        $display("reset override: q=%h cnt=%0d", q, chg_cnt);
        rst = 1'b0; load = 1'b0; cnt_clr = 1'b0; mode = 2'b10; j = 8'h11;
        step();
        total++; if (q !== 8'h11) begin bad++; $display("FAIL post_rst_q got=%h exp=11", q); end
        total++; if (chg_cnt !== 8'd1) begin bad++; $display("FAIL post_rst_cnt got=%0d exp=1", chg_cnt); end
        $display("first edge after reset: q=%h cnt=%0d", q, chg_cnt);
    endtask

    task automatic test_saturation();
        logic [7:0] pat [4];
        pat[0] = 8'hFF; pat[1] = 8'h00; pat[2] = 8'hFF; pat[3] = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b1; mode = 2'b10; load = 1'b0; cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            j = pat[i];
            step();
            $display("sat edge %0d: q2=%h cnt2=%0d", i, q2, chg_cnt2);
        end
        total++; if (chg_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d exp=3", chg_cnt2); end
        total++; if (chg_cnt !== 8'd4) begin bad++; $display("FAIL wide_cnt got=%0d exp=4", chg_cnt); end
        j = 8'h0F; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        total++; if (chg_cnt2 !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", chg_cnt2); end
        total++; if (q2 !== 8'h0F) begin bad++; $display("FAIL clr_q got=%h exp=0F", q2); end
        total++; if (changed2 !== 8'h0F) begin bad++; $display("FAIL clr_changed got=%h exp=0F", changed2); end
        total++; if (qb2 !== 8'hF0) begin bad++; $display("FAIL clr_qb got=%h exp=F0", qb2); end
        total++; if (sr_err2 !== 1'b0) begin bad++; $display("FAIL clr_sr_err got=%b exp=0", sr_err2); end
        $display("cnt_clr: q2=%h changed2=%h cnt2=%0d", q2, changed2, chg_cnt2);
        j = 8'hF0;
        step();
        total++; if (chg_cnt2 !== 2'd1) begin bad++; $display("FAIL after_clr_cnt got=%0d exp=1", chg_cnt2); end
        $display("after clr: cnt2=%0d", chg_cnt2);
    endtask

    initial begin
        test_reset();
        test_jk();
        test_toggle_mode();
        test_sr();
        test_load();
        test_reset_override();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
